// File: rtl/udp_pkg.sv
// udp_pkg: shared constants and types for the UDP stream arbiter.
//   DATA_W_DEFAULT : default stream data width
//   BEAT_CNT_W     : width of the saturating per-packet beat counter
//   arb_state_t    : arbiter FSM state (IDLE, PASS)
package udp_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned BEAT_CNT_W     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/udp_rr_pick.sv
// udp_rr_pick: combinational round-robin picker.
//   i_req    : request vector, one bit per source
//   i_rr_ptr : index where the search starts; search ascends modulo NUM_SRC
//   o_winner : first requesting index found from i_rr_ptr
//   o_any    : high when any request is set
module udp_rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_idx = IDX_W'((32'(i_rr_ptr) + i) % NUM_SRC);
            if (!o_any && i_req[w_idx]) begin
                o_any    = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/udp_stream_arbiter.sv
// udp_stream_arbiter: packet-locked round-robin merge of NUM_SRC AXI-stream
// sources into one stream toward the UDP buffer.
//   clk, rst        : clock, synchronous active-high reset
//   s_valid/s_ready : per-source handshake
//   s_data, s_last  : per-source payload (source i at [i*DATA_W +: DATA_W])
//   m_valid/m_ready : merged-stream handshake
//   m_data, m_last  : merged payload, combinational from the locked source
//   grant_idx       : currently locked source
//   busy            : high while a packet is locked (PASS)
//   pkt_count       : per-source completed-packet counters, 16 bits each,
//                     present only when UDP_ARB_STATS_EN is defined
module udp_stream_arbiter
    import udp_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         s_valid,
    output logic [NUM_SRC-1:0]         s_ready,
    input  logic [NUM_SRC*DATA_W-1:0]  s_data,
    input  logic [NUM_SRC-1:0]         s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_last,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       busy
`ifdef UDP_ARB_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]      pkt_count
`endif
);

    localparam int unsigned      IDX_W    = $clog2(NUM_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    arb_state_t            r_state;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    logic [IDX_W-1:0]      w_winner;
    logic                  w_any;
    logic                  w_hs;
    logic                  w_done;
    logic [IDX_W-1:0]      w_next_ptr;

    udp_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req    (s_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Zero-latency datapath: the locked source is muxed straight through.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        s_ready = '0;
        if (r_state == PASS) begin
            m_valid          = s_valid[r_grant];
            m_data           = s_data[32'(r_grant) * DATA_W +: DATA_W];
            m_last           = s_last[r_grant];
            s_ready[r_grant] = m_ready;
        end
    end

    assign w_hs       = m_valid & m_ready;
    assign w_done     = w_hs & m_last;
    assign w_next_ptr = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
    assign grant_idx  = r_grant;
    assign busy       = (r_state == PASS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= PASS;
                    end
                end
                PASS: begin
                    // Lock holds until the last beat is accepted, even if
                    // the granted source drops s_valid.
                    if (w_hs && (r_beat_cnt != '1)) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_done) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef UDP_ARB_STATS_EN
    logic [NUM_SRC*16-1:0] r_pkt_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count <= '0;
        end else if (w_done) begin
            r_pkt_count[32'(r_grant) * 16 +: 16] <= r_pkt_count[32'(r_grant) * 16 +: 16] + 16'd1;
        end
    end

    assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_udp_stream_arbiter.sv
// tb_udp_stream_arbiter: self-checking bench for udp_stream_arbiter.
// Sources replay queued packets; expected merged beats are queued in serve
// order and popped as the merged stream hands off.
module tb_udp_stream_arbiter;

    localparam int NS = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready;
    logic [NS*DW-1:0]  s_data;
    logic [NS-1:0]     s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic [IW-1:0]     grant_idx;
    logic              busy;
`ifdef UDP_ARB_STATS_EN
    logic [NS*16-1:0]  pkt_count;
`endif

    always #5 clk = ~clk;

    udp_stream_arbiter #(
        .NUM_SRC (NS),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef UDP_ARB_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    typedef struct packed {
        logic [IW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int src;
        int nbeats;
        int base;
        int exp_grant;
        int exp_ticks;
    } vec_t;

    beat_t         pend_q[$];
    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            hs_cnt = 0;
    int            last_cyc = 0;
    int            last_gap = 0;
    bit            after_last = 1'b0;
    int            mlast_cnt = 0;
    logic          mr_want = 1'b1;
    logic [NS-1:0] gate = '0;
    logic [NS-1:0] acc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int src, input int data, input bit last);
        beat_t b;
        b.src  = IW'(src);
        b.data = DW'(data);
        b.last = last;
        return b;
    endfunction

    function automatic void load_pkt(input int src, input int n, input int base);
        for (int k = 0; k < n; k++) pend_q.push_back(mk_beat(src, base + k, k == n - 1));
    endfunction

    function automatic void exp_pkt(input int src, input int n, input int base);
        for (int k = 0; k < n; k++) exp_q.push_back(mk_beat(src, base + k, k == n - 1));
    endfunction

    // Each source presents the oldest pending beat tagged with its index.
    task automatic drive();
        logic [NS-1:0] found;
        found   = '0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = mr_want;
        for (int k = 0; k < pend_q.size(); k++) begin
            int s;
            s = int'(pend_q[k].src);
            if (!found[s]) begin
                found[s]          = 1'b1;
                s_valid[s]        = ~gate[s];
                s_data[s*DW +: DW] = pend_q[k].data;
                s_last[s]         = pend_q[k].last;
            end
        end
    endtask

    task automatic retire();
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                int idx;
                idx = -1;
                for (int k = 0; k < pend_q.size(); k++)
                    if (idx < 0 && pend_q[k].src == IW'(i)) idx = k;
                if (idx >= 0) pend_q.delete(idx);
            end
        end
        acc = '0;
    endtask

    // Advance one cycle; returns at the negedge with outputs settled.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        retire();
        drive();
        @(negedge clk);
        acc = s_valid & s_ready;
        if (m_valid && m_ready) begin
            hs_cnt++;
            if (after_last) last_gap = cyc - last_cyc;
            after_last = m_last;
            if (m_last) begin
                last_cyc = cyc;
                mlast_cnt++;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h src %0d, expected no beat",
                         m_data, grant_idx);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 32'(m_data), 32'(e.data));
                check("beat_last", 32'(m_last), 32'(e.last));
                check("beat_src", 32'(grant_idx), 32'(e.src));
            end
        end
    endtask

    task automatic run_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done"}, 32'(n < budget), 1);
    endtask

    task automatic run_hs(input string name, input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 30) begin
            tick();
            n++;
        end
        check(name, 32'(hs_cnt >= target), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend_q.delete();
        exp_q.delete();
        acc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   n;
        int   hs0;
        int   bad;
        int   ml0;
        logic [DW-1:0] hold;

        vecs[0] = '{src: 1, nbeats: 3, base: 'h1100, exp_grant: 1, exp_ticks: 3};
        vecs[1] = '{src: 0, nbeats: 1, base: 'h1200, exp_grant: 0, exp_ticks: 1};
        vecs[2] = '{src: 3, nbeats: 2, base: 'h1300, exp_grant: 3, exp_ticks: 2};
        vecs[3] = '{src: 2, nbeats: 4, base: 'h1400, exp_grant: 2, exp_ticks: 4};
        vecs[4] = '{src: 1, nbeats: 1, base: 'h1500, exp_grant: 1, exp_ticks: 1};

        rst = 1'b1;
        drive();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_idx), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_s_ready", 32'(s_ready), 0);

        // Single-source packets: one-cycle grant latency, back to IDLE after last beat.
        for (int v = 0; v < 5; v++) begin
            load_pkt(vecs[v].src, vecs[v].nbeats, vecs[v].base);
            exp_pkt(vecs[v].src, vecs[v].nbeats, vecs[v].base);
            tick();
            check("lat_busy_low", 32'(busy), 0);
            check("lat_m_valid_low", 32'(m_valid), 0);
            tick();
            check("vec_grant", 32'(grant_idx), 32'(vecs[v].exp_grant));
            check("vec_busy", 32'(busy), 1);
            n = 0;
            while (busy && n < 20) begin
                tick();
                n++;
            end
            check("vec_ticks", 32'(n), 32'(vecs[v].exp_ticks));
            check("vec_sb_empty", 32'(exp_q.size()), 0);
            tick();
        end

        // Src0 and src2 together from reset: src0 first, one bubble, then src2.
        do_reset();
        after_last = 1'b0;
        last_gap   = 0;
        load_pkt(0, 2, 'h2000);
        load_pkt(2, 2, 'h2200);
        exp_pkt(0, 2, 'h2000);
        exp_pkt(2, 2, 'h2200);
        run_done("rr_02", 30);
        check("rr_bubble_gap", 32'(last_gap), 2);
        // rr_ptr is now 3: src3 beats src0.
        load_pkt(0, 1, 'h2300);
        load_pkt(3, 1, 'h2400);
        exp_pkt(3, 1, 'h2400);
        exp_pkt(0, 1, 'h2300);
        tick();
        tick();
        check("rr_ptr3_grant", 32'(grant_idx), 3);
        run_done("rr_30", 30);

        // Src3 locked; src0 arrives mid-packet and must wait.
        load_pkt(3, 4, 'h3000);
        exp_pkt(3, 4, 'h3000);
        tick();
        tick();
        load_pkt(0, 2, 'h3100);
        exp_pkt(0, 2, 'h3100);
        bad = 0;
        n   = 0;
        while (busy && grant_idx == 2'd3 && n < 20) begin
            if (s_ready[0] !== 1'b0) bad++;
            tick();
            n++;
        end
        check("no_preempt", 32'(bad), 0);
        tick();
        check("next_grant_src0", 32'(grant_idx), 0);
        check("next_grant_busy", 32'(busy), 1);
        run_done("preempt", 30);

        // m_ready held low 5 cycles mid-packet.
        hs0 = hs_cnt;
        load_pkt(1, 5, 'h4000);
        exp_pkt(1, 5, 'h4000);
        run_hs("stall_pre", hs0 + 2);
        mr_want = 1'b0;
        tick();
        hold = m_data;
        bad  = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_ready[1] !== 1'b0 || m_data !== hold || m_valid !== 1'b1) bad++;
            if (i < 4) tick();
        end
        check("stall_stable", 32'(bad), 0);
        check("stall_data", 32'(hold), 'h4002);
        mr_want = 1'b1;
        run_done("stall", 30);
        check("stall_beats", 32'(hs_cnt - hs0), 5);

        // Granted src1 drops s_valid mid-packet; src2 waits behind the lock.
        hs0 = hs_cnt;
        load_pkt(1, 3, 'h5000);
        exp_pkt(1, 3, 'h5000);
        run_hs("drop_pre", hs0 + 1);
        gate[1] = 1'b1;
        load_pkt(2, 2, 'h5100);
        exp_pkt(2, 2, 'h5100);
        tick();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy !== 1'b1 || grant_idx !== 2'd1 || m_valid !== 1'b0 || s_ready[2] !== 1'b0)
                bad++;
            tick();
        end
        check("drop_hold_lock", 32'(bad), 0);
        gate[1] = 1'b0;
        run_done("drop", 40);

        // Reset at beat 2 of 4 (rr_ptr is 3 here, so a stale pointer would pick src3).
        hs0 = hs_cnt;
        load_pkt(1, 4, 'h6000);
        exp_q.push_back(mk_beat(1, 'h6000, 1'b0));
        exp_q.push_back(mk_beat(1, 'h6001, 1'b0));
        run_hs("trunc_pre", hs0 + 2);
        ml0 = mlast_cnt;
        rst = 1'b1;
        pend_q.delete();
        exp_q.delete();
        acc = '0;
        tick();
        check("trunc_busy", 32'(busy), 0);
        check("trunc_grant", 32'(grant_idx), 0);
        check("trunc_m_valid", 32'(m_valid), 0);
        check("trunc_m_last", 32'(m_last), 0);
        check("trunc_s_ready", 32'(s_ready), 0);
        rst = 1'b0;
        check("trunc_no_last", 32'(mlast_cnt - ml0), 0);
        load_pkt(2, 1, 'h6100);
        load_pkt(3, 1, 'h6200);
        exp_pkt(2, 1, 'h6100);
        exp_pkt(3, 1, 'h6200);
        tick();
        tick();
        check("post_rst_grant", 32'(grant_idx), 2);
        run_done("post_rst", 30);

`ifdef UDP_ARB_STATS_EN
        do_reset();
        load_pkt(1, 1, 'h7000);
        load_pkt(0, 2, 'h7100);
        exp_pkt(0, 2, 'h7100);
        exp_pkt(1, 1, 'h7000);
        run_done("stats_a", 30);
        load_pkt(1, 2, 'h7200);
        exp_pkt(1, 2, 'h7200);
        run_done("stats_b", 30);
        check("pkt_count0", 32'(pkt_count[0 +: 16]), 1);
        check("pkt_count1", 32'(pkt_count[16 +: 16]), 2);
        check("pkt_count2", 32'(pkt_count[32 +: 16]), 0);
        check("pkt_count3", 32'(pkt_count[48 +: 16]), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
